// File: rtl/mem_bus_master.sv
// Wishbone classic master: one outstanding core request, registered bus controls, held response.
// Optional ack timeout abort is compiled in with MEM_BUS_TIMEOUT_EN.
`ifndef EXT_ADDR_W
`define EXT_ADDR_W 24
`endif
`ifndef RW
`define RW 16
`endif

module mem_bus_master #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [`EXT_ADDR_W-1:0] i_req_addr,
    input  logic                   i_req_we,
    input  logic [`RW-1:0]         i_req_data,
    input  logic [1:0]             i_req_sel,
    output logic                   o_resp_valid,
    input  logic                   i_resp_ready,
    output logic [15:0]            o_resp_data,
    output logic                   o_resp_err,
    output logic                   o_wb_cyc,
    output logic                   o_wb_stb,
    output logic                   o_wb_we,
    output logic [23:0]            o_wb_adr,
    output logic [15:0]            o_wb_dat,
    output logic [1:0]             o_wb_sel,
    input  logic                   i_wb_ack,
    input  logic                   i_wb_err,
    input  logic [15:0]            i_wb_dat
);

    // state | meaning
    // IDLE  | ready for a core request, bus idle
    // BUS   | cyc/stb asserted, waiting for ack, err (or timeout)
    // RESP  | response held until the core takes it
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);
    logic [7:0] r_tmo_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^(8'(TIMEOUT_CYC));
`endif

    assign o_req_ready = (r_state == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_adr     <= '0;
            o_wb_dat     <= '0;
            o_wb_sel     <= '0;
            o_resp_valid <= 1'b0;
            o_resp_data  <= '0;
            o_resp_err   <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        o_wb_adr  <= i_req_addr;
                        o_wb_we   <= i_req_we;
                        o_wb_dat  <= i_req_data;
                        o_wb_sel  <= i_req_sel;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        r_state   <= S_BUS;
`ifdef MEM_BUS_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                S_BUS: begin
                    // err wins over a simultaneous ack
                    if (i_wb_err) begin
                        o_wb_cyc     <= 1'b0;
                        o_wb_stb     <= 1'b0;
                        o_resp_valid <= 1'b1;
                        o_resp_data  <= '0;
                        o_resp_err   <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (i_wb_ack) begin
                        o_wb_cyc     <= 1'b0;
                        o_wb_stb     <= 1'b0;
                        o_resp_valid <= 1'b1;
                        o_resp_data  <= o_wb_we ? 16'h0000 : i_wb_dat;
                        o_resp_err   <= 1'b0;
                        r_state      <= S_RESP;
`ifdef MEM_BUS_TIMEOUT_EN
                    end else if (r_tmo_cnt + 8'd1 == TMO_LIMIT) begin
                        o_wb_cyc     <= 1'b0;
                        o_wb_stb     <= 1'b0;
                        o_resp_valid <= 1'b1;
                        o_resp_data  <= '0;
                        o_resp_err   <= 1'b1;
                        r_tmo_cnt    <= TMO_LIMIT;
                        r_state      <= S_RESP;
                    end else begin
                        r_tmo_cnt    <= r_tmo_cnt + 8'd1;
`endif
                    end
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        o_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
